// File: rtl/spi_slave_if_if.sv
// Bus bundle between the SPI serial front end and its neighbours:
// the SPI pins on one side, the RAM word/byte handshake on the other.
interface spi_slave_if_if #(
    parameter int DATA_W = 8
);
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  SS_n,
        input  MOSI,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid
    );

    modport master (
        output SS_n,
        output MOSI,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises {opcode, payload} frames from MOSI and
// serialises the RAM read byte back onto MISO during read-data frames.
module spi_slave_if #(
    parameter int DATA_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    spi_slave_if_if.slave bus
);

    localparam int WORD_W = DATA_W + 2;
    localparam int CNT_W  = $clog2(WORD_W);
    localparam int TXC_W  = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t              state, next_state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W:0]     rx_shift;
    logic [WORD_W-1:0]   rx_data_r;
    logic                rx_valid_r;
    logic                rx_done;
    logic                rd_addr_seen;
    logic [DATA_W-1:0]   tx_shift;
    logic [TXC_W-1:0]    tx_cnt;
    logic                tx_busy;
    logic                tx_done;
    logic                miso_r;

    logic                abort;
    logic                shift_in;
    logic                frame_done;
    logic                tx_load;
    logic                tx_step;

    always_comb begin
        next_state = state;
        abort      = 1'b0;
        shift_in   = 1'b0;
        frame_done = 1'b0;
        tx_load    = 1'b0;
        tx_step    = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.SS_n) next_state = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end else begin
                    shift_in = 1'b1;
                    if (!bus.MOSI)        next_state = WRITE;
                    else if (rd_addr_seen) next_state = READ_DATA;
                    else                   next_state = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end else if (!rx_done) begin
                    shift_in = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_W)) frame_done = 1'b1;
                end else if (state == READ_DATA) begin
                    // One byte per read-data frame; tx_valid is only honoured while waiting for it
                    if (tx_busy)                      tx_step = 1'b1;
                    else if (!tx_done && bus.tx_valid) tx_load = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                abort      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            rx_done      <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            miso_r       <= 1'b0;
        end else begin
            state      <= next_state;
            rx_valid_r <= frame_done;

            if (abort || state == IDLE) begin
                bit_cnt <= '0;
                rx_done <= 1'b0;
                tx_busy <= 1'b0;
                tx_done <= 1'b0;
                tx_cnt  <= '0;
                miso_r  <= 1'b0;
            end

            if (shift_in) begin
                rx_shift <= {rx_shift[DATA_W-1:0], bus.MOSI};
                if (state != CHK_CMD) bit_cnt <= bit_cnt + 1'b1;
            end

            if (frame_done) begin
                rx_data_r <= {rx_shift, bus.MOSI};
                rx_done   <= 1'b1;
                if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                if (state == READ_DATA) rd_addr_seen <= 1'b0;
            end

            if (tx_load) begin
                miso_r   <= bus.tx_data[DATA_W-1];
                tx_shift <= {bus.tx_data[DATA_W-2:0], 1'b0};
                tx_cnt   <= TXC_W'(DATA_W - 1);
                tx_busy  <= 1'b1;
            end

            if (tx_step) begin
                if (tx_cnt != '0) begin
                    miso_r   <= tx_shift[DATA_W-1];
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    tx_cnt   <= tx_cnt - 1'b1;
                end else begin
                    miso_r  <= 1'b0;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end
            end
        end
    end

    assign bus.MISO     = miso_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: stimulus queues expected rx words and
// MISO bits, a negedge monitor pops and compares them.
module tb_spi_slave_if;

    localparam int DATA_W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;
    bit   mon_en;

    logic [DATA_W+1:0] rx_q[$];
    logic              miso_q[$];

    spi_slave_if_if #(.DATA_W(DATA_W)) bus ();

    spi_slave_if #(.DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rx_valid) begin
                if (rx_q.size() == 0) begin
                    chk("rx_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [DATA_W+1:0] e;
                    e = rx_q.pop_front();
                    chk("rx_data", 32'(bus.rx_data), 32'(e));
                end
            end
            begin
                logic em;
                em = (miso_q.size() != 0) ? miso_q.pop_front() : 1'b0;
                chk("miso", 32'(bus.MISO), 32'(em));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // nbits < 10 aborts the frame by raising SS_n where the next bit would be sampled
    task automatic send_frame(input logic [DATA_W+1:0] w, input int nbits, input bit keep_low);
        if (nbits == DATA_W + 2) rx_q.push_back(w);
        bus.SS_n = 1'b0;
        tick();
        for (int i = DATA_W + 1; i > DATA_W + 1 - nbits; i--) begin
            bus.MOSI = w[i];
            tick();
        end
        bus.MOSI = 1'b0;
        if (!keep_low || nbits != DATA_W + 2) begin
            bus.SS_n = 1'b1;
            tick();
        end
    endtask

    task automatic do_tx(input logic [DATA_W-1:0] d, input bit expect_out);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        if (expect_out)
            for (int i = DATA_W - 1; i >= 0; i--) miso_q.push_back(d[i]);
        tick();
        tick();
        bus.tx_valid = 1'b1;
        bus.tx_data  = ~d;
        tick();
        bus.tx_valid = 1'b0;
        repeat (DATA_W + 2) tick();
        bus.SS_n = 1'b1;
        tick();
    endtask

    initial begin
        checks       = 0;
        passed       = 0;
        mon_en       = 1'b0;
        rst_n        = 1'b0;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        repeat (2) tick();
        chk("reset_miso", 32'(bus.MISO), 32'd0);
        chk("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        tick();

        // stray tx_valid during a write frame must not reach MISO
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        send_frame(10'h0A5, 10, 1'b0);
        bus.tx_valid = 1'b0;
        send_frame(10'h13C, 10, 1'b0);
        send_frame(10'h207, 10, 1'b0);
        send_frame(10'h355, 10, 1'b1);
        do_tx(8'hC3, 1'b1);

        // read addr, then write: rd_addr_seen survives the write
        send_frame(10'h2AA, 10, 1'b0);
        send_frame(10'h1F0, 10, 1'b0);
        send_frame(10'h30F, 10, 1'b1);
        do_tx(8'h5A, 1'b1);

        // aborts: after 5 bits, and on the bit-0 edge
        send_frame(10'h0FF, 5, 1'b0);
        send_frame(10'h0C3, 9, 1'b0);
        send_frame(10'h066, 10, 1'b0);
        chk("rx_data_hold", 32'(bus.rx_data), 32'h066);

        // reset during MISO shift after 3 bits
        send_frame(10'h2F0, 10, 1'b0);
        send_frame(10'h3F0, 10, 1'b1);
        bus.tx_data  = 8'hA7;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) miso_q.push_back(bus.tx_data[i]);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        miso_q.delete();
        rst_n    = 1'b1;
        bus.SS_n = 1'b1;
        chk("mid_reset_miso", 32'(bus.MISO), 32'd0);
        chk("mid_reset_rx_data", 32'(bus.rx_data), 32'd0);
        tick();

        // reset clears rd_addr_seen: next 1x frame is a read-addr frame
        send_frame(10'h211, 10, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(10'h322, 10, 1'b1);
        do_tx(8'hFF, 1'b0);
        send_frame(10'h333, 10, 1'b1);
        do_tx(8'h81, 1'b1);

        for (int i = 0; i < 20 && (rx_q.size() != 0 || miso_q.size() != 0); i++) tick();
        chk("rx_q_drained", 32'(rx_q.size()), 32'd0);
        chk("miso_q_drained", 32'(miso_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
